// File: rtl/sysid_pkg.sv
// Shared types and constants for the system ID checker.
package sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID_REQ,
        ST_ID_WAIT,
        ST_TS_REQ,
        ST_TS_WAIT,
        ST_DONE
    } state_t;

    localparam logic        SYSID_ADDR_ID          = 1'b0;
    localparam logic        SYSID_ADDR_TS          = 1'b1;
    localparam logic [31:0] DEF_EXPECTED_ID        = 32'h0000000B;
    localparam logic [31:0] DEF_EXPECTED_TIMESTAMP = 32'h56582551;
    localparam int          TMO_W                  = 16;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read link between the checker and the sysid slave.
interface sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address, avm_read,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_read,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/sysid_rd_timeout.sv
// Saturating per-read cycle counter; expired holds once the limit is reached.
module sysid_rd_timeout
    import sysid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != LIMIT)
            cnt <= cnt + TMO_W'(1);
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/sysid_checker.sv
// Reads sysid ID/timestamp once per run and publishes captured values and
// pass/timeout status for boot gating.
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TIMESTAMP,
    parameter bit          CHECK_TIMESTAMP    = 1'b1,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    sysid_checker_if.master        avm,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [31:0]            id_value,
    output logic [31:0]            ts_value
);

    state_t state, state_nx;
    logic   pend, go;
    logic   tmo_clr, tmo_en, tmo_exp, tmo_hit;
    logic   id_ok, ts_ok;

    // DONE with busy still high is the compare cycle; a start there is dropped.
    assign go = (start || pend) && (state == ST_IDLE || (state == ST_DONE && !busy));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        avm.avm_read    = 1'b0;
        avm.avm_address = SYSID_ADDR_ID;
        tmo_en          = 1'b0;
        tmo_hit         = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: if (go) state_nx = ST_ID_REQ;
            ST_ID_REQ: begin
                avm.avm_read = 1'b1;
                tmo_en       = 1'b1;
                if (tmo_exp) begin
                    tmo_hit  = 1'b1;
                    state_nx = ST_DONE;
                end else if (!avm.avm_waitrequest)
                    state_nx = ST_ID_WAIT;
            end
            ST_ID_WAIT: begin
                tmo_en = 1'b1;
                if (avm.avm_readdatavalid)
                    state_nx = ST_TS_REQ;
                else if (tmo_exp) begin
                    tmo_hit  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_TS_REQ: begin
                avm.avm_read    = 1'b1;
                avm.avm_address = SYSID_ADDR_TS;
                tmo_en          = 1'b1;
                if (tmo_exp) begin
                    tmo_hit  = 1'b1;
                    state_nx = ST_DONE;
                end else if (!avm.avm_waitrequest)
                    state_nx = ST_TS_WAIT;
            end
            ST_TS_WAIT: begin
                avm.avm_address = SYSID_ADDR_TS;
                tmo_en          = 1'b1;
                if (avm.avm_readdatavalid)
                    state_nx = ST_DONE;
                else if (tmo_exp) begin
                    tmo_hit  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign tmo_clr = (state_nx == ST_ID_REQ && state != ST_ID_REQ) ||
                     (state_nx == ST_TS_REQ && state != ST_TS_REQ);

    sysid_rd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    assign id_ok = (id_value == EXPECTED_ID);
    assign ts_ok = !CHECK_TIMESTAMP || (ts_value == EXPECTED_TIMESTAMP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= AUTO_START;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            pend <= 1'b0;
            if (go) begin
                busy    <= 1'b1;
                done    <= 1'b0;
                pass    <= 1'b0;
                timeout <= 1'b0;
            end else if (tmo_hit) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= 1'b0;
                timeout <= 1'b1;
            end else if (state == ST_DONE && !done) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= id_ok && ts_ok && !timeout;
            end
            if (state == ST_ID_WAIT && avm.avm_readdatavalid)
                id_value <= avm.avm_readdata;
            if (state == ST_TS_WAIT && avm.avm_readdatavalid)
                ts_value <= avm.avm_readdata;
        end
    end

endmodule
